// File: rtl/interrupt_response.sv
// CPU-side interrupt responder: takes requests at instruction boundaries, keeps a nesting stack
// of return PCs, redirects fetch to vectors and back on ERET, and drives masks to the controller.
module interrupt_response #(
    parameter int unsigned          ADDR_W     = 32,
    parameter int unsigned          DEPTH      = 4,
    parameter logic [ADDR_W-1:0]    VEC_BASE   = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0]    VEC_STRIDE = ADDR_W'(32'h0000_0020)
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              IntRequest,
    input  logic [1:0]        IntNum,
    input  logic              InstrDone,
    input  logic [ADDR_W-1:0] NextPC,
    input  logic              ERET,
    output logic              IntEnable,
    output logic              INM0,
    output logic              INM1,
    output logic              INM2,
    output logic              INM3,
    output logic              Redirect,
    output logic [ADDR_W-1:0] RedirectPC,
    output logic              ERETOut,
    output logic              EretErr,
    output logic [2:0]        Level
);

    localparam logic [2:0] LevelMax = 3'(DEPTH);

    typedef enum logic [1:0] {
        StRun,
        StWaitBnd,
        StVector,
        StReturn
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        level_q, level_d;
    logic [1:0]        pend_num_q, pend_num_d;
    logic [ADDR_W-1:0] stack_pc_q  [DEPTH];
    logic [ADDR_W-1:0] stack_pc_d  [DEPTH];
    logic [1:0]        stack_num_q [DEPTH];
    logic [1:0]        stack_num_d [DEPTH];

    logic              int_enable_q, int_enable_d;
    logic              redirect_q, redirect_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              eret_out_q, eret_out_d;
    logic              eret_err_q, eret_err_d;
    logic [3:0]        mask_q, mask_d;

    logic [ADDR_W-1:0] top_pc;
    logic [1:0]        top_num_n;
    logic [ADDR_W-1:0] vec_addr;

    assign vec_addr = VEC_BASE + ADDR_W'(pend_num_q) * VEC_STRIDE;

    always_comb begin
        top_pc = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (level_q == 3'(i + 1)) begin
                top_pc = stack_pc_q[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        pend_num_d    = pend_num_q;
        stack_pc_d    = stack_pc_q;
        stack_num_d   = stack_num_q;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        eret_out_d    = 1'b0;
        eret_err_d    = 1'b0;

        unique case (state_q)
            StRun: begin
                // ERET takes precedence; a concurrent request is simply sampled again later.
                if (InstrDone && ERET) begin
                    if (level_q != 3'd0) begin
                        level_d       = level_q - 3'd1;
                        state_d       = StReturn;
                        redirect_d    = 1'b1;
                        redirect_pc_d = top_pc;
                        eret_out_d    = 1'b1;
                    end else begin
                        eret_err_d = 1'b1;
                    end
                end else if (IntRequest && int_enable_q) begin
                    pend_num_d = IntNum;
                    state_d    = StWaitBnd;
                end
            end
            StWaitBnd: begin
                if (InstrDone) begin
                    if (ERET && level_q != 3'd0) begin
                        // Tail-chain: the finishing handler's EPC is reused for the new one.
                        for (int i = 0; i < int'(DEPTH); i++) begin
                            if (level_q == 3'(i + 1)) begin
                                stack_num_d[i] = pend_num_q;
                            end
                        end
                        eret_out_d = 1'b1;
                    end else begin
                        if (level_q < LevelMax) begin
                            for (int i = 0; i < int'(DEPTH); i++) begin
                                if (level_q == 3'(i)) begin
                                    stack_pc_d[i]  = NextPC;
                                    stack_num_d[i] = pend_num_q;
                                end
                            end
                            level_d = level_q + 3'd1;
                        end
                        eret_err_d = ERET;
                    end
                    state_d       = StVector;
                    redirect_d    = 1'b1;
                    redirect_pc_d = vec_addr;
                end
            end
            StVector: state_d = StRun;
            StReturn: state_d = StRun;
            default:  state_d = StRun;
        endcase
    end

    always_comb begin
        top_num_n = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (level_d == 3'(i + 1)) begin
                top_num_n = stack_num_d[i];
            end
        end
        // Sources at or below the in-service priority are masked; higher ones may nest.
        for (int i = 0; i < 4; i++) begin
            mask_d[i] = (level_d != 3'd0) && (2'(i) <= top_num_n);
        end
        int_enable_d = (state_d == StRun) && (level_d < LevelMax);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= StRun;
            level_q       <= 3'd0;
            pend_num_q    <= 2'd0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                stack_pc_q[i]  <= '0;
                stack_num_q[i] <= 2'd0;
            end
            int_enable_q  <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            eret_out_q    <= 1'b0;
            eret_err_q    <= 1'b0;
            mask_q        <= 4'd0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            pend_num_q    <= pend_num_d;
            stack_pc_q    <= stack_pc_d;
            stack_num_q   <= stack_num_d;
            int_enable_q  <= int_enable_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            eret_out_q    <= eret_out_d;
            eret_err_q    <= eret_err_d;
            mask_q        <= mask_d;
        end
    end

    assign IntEnable  = int_enable_q;
    assign INM0       = mask_q[0];
    assign INM1       = mask_q[1];
    assign INM2       = mask_q[2];
    assign INM3       = mask_q[3];
    assign Redirect   = redirect_q;
    assign RedirectPC = redirect_pc_q;
    assign ERETOut    = eret_out_q;
    assign EretErr    = eret_err_q;
    assign Level      = level_q;

endmodule

// File: tb/tb_interrupt_response.sv
// Directed bench for interrupt_response: reset, entry/exit, nesting, tail-chain, spurious ERET,
// and ERET/request collision, against hand-computed expectations.
module tb_interrupt_response;

    logic        clk;
    logic        clr_n;
    logic        IntRequest;
    logic [1:0]  IntNum;
    logic        InstrDone;
    logic [31:0] NextPC;
    logic        ERET;
    logic        IntEnable;
    logic        INM0, INM1, INM2, INM3;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        ERETOut;
    logic        EretErr;
    logic [2:0]  Level;

    int n_checks = 0;
    int n_pass   = 0;

    interrupt_response dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .IntRequest (IntRequest),
        .IntNum     (IntNum),
        .InstrDone  (InstrDone),
        .NextPC     (NextPC),
        .ERET       (ERET),
        .IntEnable  (IntEnable),
        .INM0       (INM0),
        .INM1       (INM1),
        .INM2       (INM2),
        .INM3       (INM3),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .ERETOut    (ERETOut),
        .EretErr    (EretErr),
        .Level      (Level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] masks();
        return {INM3, INM2, INM1, INM0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        IntRequest = 1'b0;
        IntNum     = 2'd0;
        InstrDone  = 1'b0;
        NextPC     = 32'd0;
        ERET       = 1'b0;
    endtask

    task automatic enter(input logic [1:0] num, input logic [31:0] pc, input logic [31:0] vec,
                         input logic [2:0] lvl, input logic [3:0] msk);
        IntRequest = 1'b1;
        IntNum     = num;
        step();
        check("enter_ie_low", 32'(IntEnable), 32'd0);
        IntRequest = 1'b0;
        InstrDone  = 1'b1;
        NextPC     = pc;
        step();
        check("enter_redirect", 32'(Redirect), 32'd1);
        check("enter_vec", RedirectPC, vec);
        check("enter_level", 32'(Level), 32'(lvl));
        check("enter_mask", 32'(masks()), 32'(msk));
        InstrDone = 1'b0;
        step();
        check("enter_redirect_end", 32'(Redirect), 32'd0);
    endtask

    task automatic do_eret(input logic [31:0] pc, input logic [2:0] lvl, input logic [3:0] msk);
        InstrDone = 1'b1;
        ERET      = 1'b1;
        step();
        InstrDone = 1'b0;
        ERET      = 1'b0;
        check("eret_redirect", 32'(Redirect), 32'd1);
        check("eret_pc", RedirectPC, pc);
        check("eret_out", 32'(ERETOut), 32'd1);
        check("eret_level", 32'(Level), 32'(lvl));
        check("eret_mask", 32'(masks()), 32'(msk));
        step();
        check("eret_out_end", 32'(ERETOut), 32'd0);
        check("eret_redirect_end", 32'(Redirect), 32'd0);
    endtask

    initial begin
        idle_inputs();
        clr_n = 1'b0;
        #12;
        check("rst_ie", 32'(IntEnable), 32'd0);
        clr_n = 1'b1;
        step();
        check("rel_ie", 32'(IntEnable), 32'd1);

        // 1: reset while waiting for a boundary
        IntRequest = 1'b1;
        IntNum     = 2'd1;
        step();
        check("wait_ie", 32'(IntEnable), 32'd0);
        IntRequest = 1'b0;
        #2 clr_n = 1'b0;
        #1;
        check("rst_mid_ie", 32'(IntEnable), 32'd0);
        check("rst_mid_level", 32'(Level), 32'd0);
        check("rst_mid_redirect", 32'(Redirect), 32'd0);
        check("rst_mid_mask", 32'(masks()), 32'd0);
        check("rst_mid_out", 32'({ERETOut, EretErr}), 32'd0);
        step();
        #2 clr_n = 1'b1;
        InstrDone = 1'b1;
        NextPC    = 32'h999;
        step();
        InstrDone = 1'b0;
        check("rel2_ie", 32'(IntEnable), 32'd1);
        check("rel2_level", 32'(Level), 32'd0);
        check("rel2_redirect", 32'(Redirect), 32'd0);

        // 2: single entry and exit
        enter(2'd2, 32'h100, 32'h3040, 3'd1, 4'b0111);
        check("in_handler_ie", 32'(IntEnable), 32'd1);
        do_eret(32'h100, 3'd0, 4'b0000);

        // 3: nesting to full depth, then unwind LIFO
        enter(2'd0, 32'h1000, 32'h3000, 3'd1, 4'b0001);
        enter(2'd1, 32'h1100, 32'h3020, 3'd2, 4'b0011);
        enter(2'd2, 32'h1200, 32'h3040, 3'd3, 4'b0111);
        enter(2'd3, 32'h1300, 32'h3060, 3'd4, 4'b1111);
        check("full_ie", 32'(IntEnable), 32'd0);
        IntRequest = 1'b1;
        IntNum     = 2'd3;
        InstrDone  = 1'b1;
        NextPC     = 32'h1400;
        step();
        step();
        idle_inputs();
        check("full_block_level", 32'(Level), 32'd4);
        check("full_block_redirect", 32'(Redirect), 32'd0);
        do_eret(32'h1300, 3'd3, 4'b0111);
        check("unfull_ie", 32'(IntEnable), 32'd1);
        do_eret(32'h1200, 3'd2, 4'b0011);
        do_eret(32'h1100, 3'd1, 4'b0001);
        do_eret(32'h1000, 3'd0, 4'b0000);

        // 4: tail-chain from handler 1 into handler 3
        enter(2'd1, 32'h200, 32'h3020, 3'd1, 4'b0011);
        IntRequest = 1'b1;
        IntNum     = 2'd3;
        step();
        IntRequest = 1'b0;
        InstrDone  = 1'b1;
        ERET       = 1'b1;
        NextPC     = 32'h240;
        step();
        idle_inputs();
        check("tc_redirect", 32'(Redirect), 32'd1);
        check("tc_vec", RedirectPC, 32'h3060);
        check("tc_eretout", 32'(ERETOut), 32'd1);
        check("tc_level", 32'(Level), 32'd1);
        check("tc_mask", 32'(masks()), 32'b1111);
        step();
        check("tc_eretout_end", 32'(ERETOut), 32'd0);
        do_eret(32'h200, 3'd0, 4'b0000);

        // 5: spurious ERET with nothing in service
        InstrDone = 1'b1;
        ERET      = 1'b1;
        step();
        idle_inputs();
        check("sp_err", 32'(EretErr), 32'd1);
        check("sp_redirect", 32'(Redirect), 32'd0);
        check("sp_eretout", 32'(ERETOut), 32'd0);
        check("sp_level", 32'(Level), 32'd0);
        step();
        check("sp_err_end", 32'(EretErr), 32'd0);

        // 6: request and ERET on the same edge
        enter(2'd0, 32'h500, 32'h3000, 3'd1, 4'b0001);
        IntRequest = 1'b1;
        IntNum     = 2'd2;
        InstrDone  = 1'b1;
        ERET       = 1'b1;
        step();
        InstrDone = 1'b0;
        ERET      = 1'b0;
        check("same_ret_pc", RedirectPC, 32'h500);
        check("same_eretout", 32'(ERETOut), 32'd1);
        check("same_level", 32'(Level), 32'd0);
        step();
        check("same_ie_back", 32'(IntEnable), 32'd1);
        step();
        check("same_req_taken", 32'(IntEnable), 32'd0);
        IntRequest = 1'b0;
        InstrDone  = 1'b1;
        NextPC     = 32'h600;
        step();
        idle_inputs();
        check("same_vec", RedirectPC, 32'h3040);
        check("same_vec_level", 32'(Level), 32'd1);
        step();
        do_eret(32'h600, 3'd0, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
